// File: rtl/param_reg_file.sv
// param_reg_file: DEPTH x WIDTH register file with one write port, two read ports,
// optional write-to-read bypass, optional hardwired-zero entry 0 and a background clear engine.
module param_reg_file #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int BYPASS    = 1,
   parameter int ZERO_REG0 = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [WIDTH-1:0]  write_data,
   output logic              write_accept,
   input  logic [ADDR_W-1:0] read_addr_0,
   output logic [WIDTH-1:0]  read_data_0,
   input  logic [ADDR_W-1:0] read_addr_1,
   output logic [WIDTH-1:0]  read_data_1,
   input  logic              clear_start,
   output logic              busy,
   output logic              clear_done
);
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH-1);
   typedef enum logic {IDLE, CLEARING} state_t;
   state_t            state, state_next;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W:0]   ptr;
   logic [ADDR_W-1:0] ra  [2];
   logic [WIDTH-1:0]  rdv [2];
   assign busy         = state == CLEARING;
   assign write_accept = write_enable & ~busy & ~clear_start & ({1'b0, write_addr} < DEPTH_V)
                         & ~(ZERO_REG0 != 0 && write_addr == '0);
   assign ra[0]        = read_addr_0;
   assign ra[1]        = read_addr_1;
   assign read_data_0  = rdv[0];
   assign read_data_1  = rdv[1];
   // out-of-range and hardwired-zero addresses mask the storage lookup entirely
   always_comb begin
      for (int p = 0; p < 2; p++)
         rdv[p] = ({1'b0, ra[p]} >= DEPTH_V || (ZERO_REG0 != 0 && ra[p] == '0)) ? '0 :
                  (BYPASS != 0 && write_accept && write_addr == ra[p]) ? write_data : mem[ra[p]];
   end
   always_comb begin
      state_next = (state == IDLE && clear_start) ? CLEARING :
                   (state == CLEARING && ptr == LAST) ? IDLE : state;
   end
   always_ff @(posedge clk) state <= reset ? IDLE : state_next;
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         clear_done <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         clear_done <= busy && ptr == LAST;
         if (busy) begin
            mem[ptr[ADDR_W-1:0]] <= '0;
            ptr                  <= ptr + (ADDR_W+1)'(1);
         end else if (clear_start)
            ptr <= '0;
         else if (write_accept)
            mem[write_addr] <= write_data;
      end
   end
endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: directed plus randomized checks of two param_reg_file configurations
// (default 4-entry bypassing file, and a 3-entry non-bypassing file with hardwired-zero entry 0).
module tb_param_reg_file;
   logic       clk = 0;
   logic       reset, write_enable, clear_start;
   logic [1:0] write_addr, read_addr_0, read_addr_1;
   logic [7:0] write_data;
   logic       acc [2], bsy [2], dne [2];
   logic [7:0] rd0 [2], rd1 [2];
   logic [7:0] mm  [2][4];
   int         left [2];
   bit         dn   [2];
   int         n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   param_reg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .ZERO_REG0(0)) u_a (
      .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .write_accept(acc[0]), .read_addr_0(read_addr_0),
      .read_data_0(rd0[0]), .read_addr_1(read_addr_1), .read_data_1(rd1[0]),
      .clear_start(clear_start), .busy(bsy[0]), .clear_done(dne[0]));

   param_reg_file #(.WIDTH(8), .DEPTH(3), .BYPASS(0), .ZERO_REG0(1)) u_b (
      .clk(clk), .reset(reset), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .write_accept(acc[1]), .read_addr_0(read_addr_0),
      .read_data_0(rd0[1]), .read_addr_1(read_addr_1), .read_data_1(rd1[1]),
      .clear_start(clear_start), .busy(bsy[1]), .clear_done(dne[1]));

   function automatic int dep(int k);  return k ? 3 : 4; endfunction
   function automatic bit byp(int k);  return k == 0;    endfunction
   function automatic bit z0(int k);   return k == 1;    endfunction

   function automatic bit exp_acc(int k);
      return write_enable && left[k] == 0 && !clear_start && int'(write_addr) < dep(k)
             && !(z0(k) && write_addr == 0);
   endfunction

   function automatic logic [7:0] exp_rd(int k, logic [1:0] a);
      if (int'(a) >= dep(k) || (z0(k) && a == 0)) return 8'h00;
      if (byp(k) && exp_acc(k) && write_addr == a) return write_data;
      return mm[k][a];
   endfunction

   task automatic chk(string tag, int k, logic [7:0] obs, logic [7:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s dut%0d observed=%h expected=%h t=%0t", tag, k, obs, expv, $time);
   endtask

   task automatic drive(bit rst, bit we, logic [1:0] wa, logic [7:0] wd,
                        logic [1:0] a0, logic [1:0] a1, bit cs);
      reset = rst; write_enable = we; write_addr = wa; write_data = wd;
      read_addr_0 = a0; read_addr_1 = a1; clear_start = cs;
   endtask

   // check outputs mid-cycle, then advance the model at the clock edge
   task automatic cycle();
      bit a [2];
      #1;
      for (int k = 0; k < 2; k++) begin
         a[k] = exp_acc(k);
         chk("write_accept", k, {7'b0, acc[k]}, {7'b0, a[k]});
         chk("read_data_0", k, rd0[k], exp_rd(k, read_addr_0));
         chk("read_data_1", k, rd1[k], exp_rd(k, read_addr_1));
         chk("busy", k, {7'b0, bsy[k]}, {7'b0, left[k] > 0});
         chk("clear_done", k, {7'b0, dne[k]}, {7'b0, dn[k]});
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            for (int i = 0; i < 4; i++) mm[k][i] = 8'h00;
            left[k] = 0;
            dn[k]   = 0;
         end else begin
            dn[k] = left[k] == 1;
            if (left[k] > 0) begin
               mm[k][dep(k) - left[k]] = 8'h00;
               left[k]--;
            end else if (clear_start) left[k] = dep(k);
            else if (a[k]) mm[k][write_addr] = write_data;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         left[k] = 0;
         dn[k]   = 0;
         for (int i = 0; i < 4; i++) mm[k][i] = 8'h00;
      end
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cycle();
      cycle();
      // post-reset: every address on both ports reads zero
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 2'(i), 2'(3 - i), 0);
         cycle();
      end
      // same-cycle bypass on port 0, then registered readback
      drive(0, 1, 2, 8'hA5, 2, 1, 0); cycle();
      drive(0, 0, 0, 0, 2, 2, 0);     cycle();
      // fill, then clear with a dropped write mid-clear and scanning reads
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 2'(i), 8'(8'h11 * (i + 1)), 2'(i), 0, 0);
         cycle();
      end
      drive(0, 0, 0, 0, 0, 3, 1); cycle();
      for (int i = 0; i < 6; i++) begin
         drive(0, i == 1, 1, 8'h99, 2'(i), 2'(3 - i), i == 2);
         cycle();
      end
      // hardwired zero entry and out-of-range address
      drive(0, 1, 0, 8'hFF, 1, 0, 0); cycle();
      drive(0, 1, 1, 8'hFF, 1, 0, 0); cycle();
      drive(0, 1, 3, 8'h7E, 3, 1, 0); cycle();
      drive(0, 0, 0, 0, 3, 1, 0);     cycle();
      // reset two cycles into a clear aborts it without a done pulse
      drive(0, 0, 0, 0, 1, 2, 1); cycle();
      drive(0, 0, 0, 0, 1, 2, 0); cycle();
      drive(1, 0, 0, 0, 1, 2, 0); cycle();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 2'(i), 1, 0);
         cycle();
      end
      // clear_start beats a same-cycle write
      drive(0, 1, 1, 8'h5A, 1, 1, 1); cycle();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 1, 2'(i), 0);
         cycle();
      end
      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 2'($urandom),
               8'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 19) == 0);
         cycle();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
